// File: rtl/imem_cache_if.sv
// imem_cache_if: bundles the fetch-side request/response handshake and the
// word-wide backing-bus handshake of the instruction cache.
//   req_*   : one-cycle request strobe plus attributes (fetch -> cache)
//   resp_*  : one-cycle response strobe plus instruction word (cache -> fetch)
//   bus_*   : miss request (cache -> memory) and fill response (memory -> cache)
// modport slave is the cache; modport master is the fetch stage plus memory.
interface imem_cache_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_fence;
    logic              req_spec;
    logic              req_instr;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic [31:0]       resp_rdata;
    logic              resp_ready;
    logic              bus_valid;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_rdata;
    logic              bus_ready;

    modport slave (
        input  req_valid, req_fence, req_spec, req_instr, req_addr, req_wdata, req_wstrb,
        output resp_rdata, resp_ready,
        output bus_valid, bus_addr,
        input  bus_rdata, bus_ready
    );

    modport master (
        output req_valid, req_fence, req_spec, req_instr, req_addr, req_wdata, req_wstrb,
        input  resp_rdata, resp_ready,
        input  bus_valid, bus_addr,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/imem_cache.sv
// imem_cache: direct-mapped, one-word-per-line, read-only instruction cache.
// Hits answer one cycle after the request; misses issue a single bus_valid
// pulse and answer in the bus_ready cycle with the bus data bypassed through.
// A fenced request sweeps every line invalid before it is serviced as a miss.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-low; restarts the invalidation sweep
//   imem   : imem_cache_if.slave (request/response and backing bus)
module imem_cache #(
    parameter int SETS   = 64,
    parameter int ADDR_W = 32
) (
    input  logic        clock,
    input  logic        reset,
    imem_cache_if.slave imem
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SETS - 1);

    localparam logic [1:0] S_INV    = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_MISS   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              hit_q, hit_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              bus_valid_q, bus_valid_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [31:0]       data_q [SETS];

    logic              fill;
    logic [IDX_W-1:0]  fill_idx, req_idx;
    logic [TAG_W-1:0]  fill_tag, req_tag, look_tag;
    logic              look_valid, hit, accept;
    logic [31:0]       look_data;

    // Lookup of the incoming address. A fill landing this very cycle is
    // forwarded so a request accepted alongside it sees the new line.
    always_comb begin
        fill     = reset && (state_q == S_MISS) && imem.bus_ready;
        fill_idx = addr_q[2 +: IDX_W];
        fill_tag = addr_q[ADDR_W-1 -: TAG_W];
        req_idx  = imem.req_addr[2 +: IDX_W];
        req_tag  = imem.req_addr[ADDR_W-1 -: TAG_W];
        if (fill && (fill_idx == req_idx)) begin
            look_valid = 1'b1;
            look_tag   = fill_tag;
            look_data  = imem.bus_rdata;
        end else begin
            look_valid = valid_q[req_idx];
            look_tag   = tag_q[req_idx];
            look_data  = data_q[req_idx];
        end
        hit = look_valid && (look_tag == req_tag);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        addr_d      = addr_q;
        hit_d       = 1'b0;
        rdata_d     = rdata_q;
        bus_valid_d = 1'b0;
        bus_addr_d  = bus_addr_q;
        valid_d     = valid_q;
        accept      = 1'b0;
        case (state_q)
            S_INV, S_FLUSH: begin
                valid_d[idx_q] = 1'b0;
                idx_d          = idx_q + IDX_W'(1);
                // Requests arriving mid-sweep wait in the pending slot.
                if (imem.req_valid) begin
                    pend_d = 1'b1;
                    addr_d = imem.req_addr;
                end
                if (idx_q == IDX_LAST) begin
                    pend_d = 1'b0;
                    if (pend_q || imem.req_valid) begin
                        // Everything was just invalidated: straight to the bus.
                        state_d     = S_MISS;
                        bus_valid_d = 1'b1;
                        bus_addr_d  = {addr_d[ADDR_W-1:2], 2'b00};
                    end else begin
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: accept = imem.req_valid;
            S_MISS: begin
                if (fill) begin
                    valid_d[fill_idx] = 1'b1;
                    rdata_d           = imem.bus_rdata;
                    state_d           = S_LOOKUP;
                    accept            = imem.req_valid;
                end
            end
            default: state_d = S_INV;
        endcase
        if (accept) begin
            addr_d = imem.req_addr;
            if (imem.req_fence) begin
                state_d = S_FLUSH;
                idx_d   = '0;
                pend_d  = 1'b1;
            end else if (hit) begin
                hit_d   = 1'b1;
                rdata_d = look_data;
            end else begin
                state_d     = S_MISS;
                bus_valid_d = 1'b1;
                bus_addr_d  = {imem.req_addr[ADDR_W-1:2], 2'b00};
            end
        end
    end

    // The valid array is not reset: the INV sweep after reset clears it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_INV;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            addr_q      <= '0;
            hit_q       <= 1'b0;
            rdata_q     <= '0;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            addr_q      <= addr_d;
            hit_q       <= hit_d;
            rdata_q     <= rdata_d;
            bus_valid_q <= bus_valid_d;
            bus_addr_q  <= bus_addr_d;
            valid_q     <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= imem.bus_rdata;
        end
    end

    // Hit responses come from the registered read; fill responses bypass bus data.
    assign imem.resp_ready = hit_q | fill;
    assign imem.resp_rdata = fill ? imem.bus_rdata : rdata_q;
    assign imem.bus_valid  = bus_valid_q;
    assign imem.bus_addr   = bus_addr_q;

    // Write-side and attribute inputs have no function in a read-only cache.
    logic unused_ok;
    assign unused_ok = ^{imem.req_spec, imem.req_instr, imem.req_wdata, imem.req_wstrb,
                         imem.req_addr[1:0], addr_q[1:0]};
endmodule

// File: tb/tb_imem_cache.sv
// tb_imem_cache: directed bench for imem_cache. A cycle-indexed expectation
// table is filled by a behavioural cache model (lines keyed by set index,
// holding the cached word address and data); one negedge process compares
// resp_ready/resp_rdata/bus_valid/bus_addr against it every cycle.
module tb_imem_cache;
    localparam int SETS = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    imem_cache_if #(.ADDR_W(32)) bif ();
    imem_cache #(.SETS(SETS), .ADDR_W(32)) dut (.clock(clock), .reset(reset), .imem(bif));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    int vecs = 0;
    int errs = 0;
    bit chk_en = 1'b0;
    int obs_resp = 0;
    logic [31:0] obs_ba [$];

    bit          exp_resp  [int];
    logic [31:0] exp_rdata [int];
    bit          exp_bv    [int];
    logic [31:0] exp_ba    [int];
    logic [31:0] ln_addr   [int];
    logic [31:0] ln_data   [int];
    int          ready_cyc = 0;
    logic [31:0] miss_wa   = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        bit er;
        bit eb;
        if (chk_en) begin
            er = exp_resp.exists(cyc);
            eb = exp_bv.exists(cyc);
            chk("resp_ready", 32'(bif.resp_ready), 32'(er));
            if (er) chk("resp_rdata", bif.resp_rdata, exp_rdata[cyc]);
            chk("bus_valid", 32'(bif.bus_valid), 32'(eb));
            if (eb) chk("bus_addr", bif.bus_addr, exp_ba[cyc]);
            if (bif.resp_ready) obs_resp++;
            if (bif.bus_valid) obs_ba.push_back(bif.bus_addr);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        bif.req_valid = 1'b0;
        bif.req_fence = 1'b0;
        bif.req_spec  = 1'b0;
        bif.bus_ready = 1'b0;
    endtask

    // Drives one request in the current cycle and records what the cache must
    // do: bv = cycle of the expected bus_valid, or -1 for a hit.
    task automatic issue(input logic [31:0] a, input bit fence, input bit spec, output int bv);
        int idx;
        logic [31:0] wa;
        wa  = a & 32'hFFFF_FFFC;
        idx = int'((a >> 2) % SETS);
        bif.req_valid = 1'b1;
        bif.req_addr  = a;
        bif.req_fence = fence;
        bif.req_spec  = spec;
        bif.req_instr = 1'b1;
        bif.req_wdata = $urandom;
        bif.req_wstrb = 4'hF;
        if (cyc < ready_cyc) begin
            bv = ready_cyc;
        end else if (fence) begin
            ln_addr.delete();
            ln_data.delete();
            bv = cyc + 1 + SETS;
        end else if (ln_addr.exists(idx) && ln_addr[idx] == wa) begin
            bv = -1;
            exp_resp[cyc + 1]  = 1'b1;
            exp_rdata[cyc + 1] = ln_data[idx];
        end else begin
            bv = cyc + 1;
        end
        if (bv >= 0) begin
            exp_bv[bv] = 1'b1;
            exp_ba[bv] = wa;
            miss_wa    = wa;
        end
    endtask

    // Backing bus answers lat cycles after bus_valid; response is same-cycle.
    task automatic reply(input int bv, input int lat, input logic [31:0] d);
        int target;
        int idx;
        target = bv + lat;
        chk("reply_sched", 32'(cyc <= target), 32'd1);
        while (cyc < target) tick();
        bif.bus_ready = 1'b1;
        bif.bus_rdata = d;
        exp_resp[cyc]  = 1'b1;
        exp_rdata[cyc] = d;
        idx = int'((miss_wa >> 2) % SETS);
        ln_addr[idx] = miss_wa;
        ln_data[idx] = d;
    endtask

    task automatic access(input logic [31:0] a, input bit fence, input bit spec,
                          input int lat, input logic [31:0] d);
        int bv;
        issue(a, fence, spec, bv);
        if (bv >= 0) reply(bv, lat, d);
        tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
        ln_addr.delete();
        ln_data.delete();
        ready_cyc = cyc + SETS;
    endtask

    initial begin
        int t0;
        int bv;
        int c;
        int base;
        bif.req_valid = 1'b0;
        bif.req_fence = 1'b0;
        bif.req_spec  = 1'b0;
        bif.req_instr = 1'b0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        bif.req_wstrb = '0;
        bif.bus_rdata = '0;
        bif.bus_ready = 1'b0;

        do_reset(3);
        t0 = cyc;
        chk_en = 1'b1;
        chk("rst_resp_ready", 32'(bif.resp_ready), 32'd0);
        chk("rst_bus_valid", 32'(bif.bus_valid), 32'd0);
        chk("rst_resp_rdata", bif.resp_rdata, 32'd0);
        chk("rst_bus_addr", bif.bus_addr, 32'd0);

        // Request held through the post-reset sweep, then a 3-cycle miss.
        repeat (5) tick();
        issue(32'h100, 1'b0, 1'b0, bv);
        chk("sweep_len", 32'(bv - t0), 32'd64);
        reply(bv, 3, 32'h0000_0013);
        #1 chk("first_fill_rdata", bif.resp_rdata, 32'h0000_0013);
        tick();

        // Hit, then a miss issued in the hit's response cycle.
        issue(32'h100, 1'b0, 1'b0, bv);
        chk("repeat_is_hit", 32'(bv), 32'hFFFF_FFFF);
        tick();
        chk("hit_rdata", bif.resp_rdata, 32'h0000_0013);
        issue(32'h104, 1'b0, 1'b0, bv);
        reply(bv, 2, 32'h0040_0093);
        tick();

        // Same-index conflict: three misses in a row.
        access(32'h300, 1'b0, 1'b0, 2, 32'h11);
        base = obs_ba.size();
        access(32'h100, 1'b0, 1'b0, 1, 32'h21);
        access(32'h200, 1'b0, 1'b0, 4, 32'h22);
        access(32'h100, 1'b0, 1'b0, 2, 32'h23);
        chk("conflict_misses", 32'(obs_ba.size() - base), 32'd3);
        if (obs_ba.size() >= base + 3) begin
            chk("conflict_addr0", obs_ba[base], 32'h100);
            chk("conflict_addr1", obs_ba[base + 1], 32'h200);
            chk("conflict_addr2", obs_ba[base + 2], 32'h100);
        end

        // Fence on a cached address returns fresh bus data.
        issue(32'h100, 1'b1, 1'b0, bv);
        c = cyc;
        chk("fence_lat", 32'(bv - c), 32'd65);
        reply(bv, 2, 32'hDEAD_BEEF);
        #1 chk("fence_rdata", bif.resp_rdata, 32'hDEAD_BEEF);
        tick();
        access(32'h100, 1'b0, 1'b0, 0, 32'h0);
        access(32'h104, 1'b0, 1'b0, 3, 32'h44);

        // Speculative miss still completes once; follow-up hits.
        issue(32'h180, 1'b0, 1'b1, bv);
        reply(bv, 5, 32'h1234_5678);
        tick();
        issue(32'h180, 1'b0, 1'b0, bv);
        chk("spec_then_hit", 32'(bv), 32'hFFFF_FFFF);
        tick();
        chk("spec_hit_rdata", bif.resp_rdata, 32'h1234_5678);

        // Reset mid-miss; a stale bus_ready two cycles later is ignored.
        issue(32'h1C0, 1'b0, 1'b0, bv);
        while (cyc < bv + 1) tick();
        do_reset(1);
        tick();
        bif.bus_ready = 1'b1;
        bif.bus_rdata = 32'hBAD0_BAD0;
        tick();
        while (cyc < ready_cyc) tick();
        issue(32'h1C0, 1'b0, 1'b0, bv);
        chk("post_rst_miss", 32'(bv - cyc), 32'd1);
        reply(bv, 2, 32'h55);
        tick();
        access(32'h100, 1'b0, 1'b0, 2, 32'h66);

        // Hit request accepted in a fill cycle.
        issue(32'h208, 1'b0, 1'b0, bv);
        reply(bv, 1, 32'h77);
        issue(32'h100, 1'b0, 1'b0, bv);
        chk("fill_cycle_hit", 32'(bv), 32'hFFFF_FFFF);
        tick();
        tick();

        repeat (3) tick();
        chk("resp_count", 32'(obs_resp), 32'd16);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
